// File: rtl/mem_ss_csr_responder.sv
// ---------------------------------------------------------------------------
// mem_ss_csr_responder
//
// AXI4-Lite 64-bit CSR slave for the memory subsystem feature. It answers
// host accesses to the EMIF DFH, EMIF status/capability, MEM_SS
// identification, scratch, status, channel-attribute and efficiency-monitor
// registers. It sits between the PCIe CSR fabric and the memory subsystem.
//
// Ports:
//   clk, rst_n             CSR clock, asynchronous active-low reset
//   s_aw* / s_w* / s_b*    AXI4-Lite write address, data and response
//   s_ar* / s_r*           AXI4-Lite read address and data
//   cal_success, cal_fail  per-channel calibration results (asynchronous)
//   effmon_en              efficiency-monitor enable (EFFMON_CTRL bit 0)
// ---------------------------------------------------------------------------
module mem_ss_csr_responder #(
  parameter int          NUM_CH         = 4,
  parameter int          ADDR_W         = 16,
  parameter logic [3:0]  DFH_FEAT_TYPE  = 4'h3,
  parameter logic [23:0] DFH_NXT_OFFSET = 24'h0,
  parameter logic        DFH_EOL        = 1'b1,
  parameter logic [3:0]  DFH_MAJOR_VER  = 4'h0,
  parameter logic [3:0]  DFH_MINOR_VER  = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [63:0]       s_wdata,
  input  logic [7:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [63:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  input  logic [NUM_CH-1:0] cal_success,
  input  logic [NUM_CH-1:0] cal_fail,
  output logic              effmon_en
);

  localparam logic [ADDR_W-1:0] ADDR_DFH         = ADDR_W'('h000);
  localparam logic [ADDR_W-1:0] ADDR_EMIF_STATUS = ADDR_W'('h008);
  localparam logic [ADDR_W-1:0] ADDR_EMIF_CAP    = ADDR_W'('h010);
  localparam logic [ADDR_W-1:0] ADDR_VERSION     = ADDR_W'('h860);
  localparam logic [ADDR_W-1:0] ADDR_FEAT_LIST   = ADDR_W'('h864);
  localparam logic [ADDR_W-1:0] ADDR_FEAT_LIST_2 = ADDR_W'('h868);
  localparam logic [ADDR_W-1:0] ADDR_IF_ATTR     = ADDR_W'('h870);
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH     = ADDR_W'('h880);
  localparam logic [ADDR_W-1:0] ADDR_STATUS      = ADDR_W'('h8B0);
  localparam logic [ADDR_W-1:0] ADDR_EFFMON_CTRL = ADDR_W'('h1000);
  localparam int                CH_ATTR_BASE     = 'h900;

  localparam logic [11:0] DFH_FEAT_ID  = 12'h009;
  localparam logic [63:0] CH_ATTR_WORD = 64'h0000_0000_0910_0003;

  // Read FSM: INIT holds off the first cycle so arready rises only after
  // reset release; RESP holds rdata until the host takes it.
  typedef enum logic [1:0] {
    RD_INIT,
    RD_IDLE,
    RD_RESP
  } rdState_e;

  typedef enum logic [1:0] {
    WR_INIT,
    WR_IDLE,
    WR_RESP
  } wrState_e;

  rdState_e          rdState_q;
  wrState_e          wrState_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [63:0]       rdata_q;
  logic              wrIdle_q;
  logic              bvalid_q;
  logic [63:0]       scratch_q;
  logic              effmonEn_q;
  logic [NUM_CH-1:0] calSuccMeta_q;
  logic [NUM_CH-1:0] calSuccSync_q;
  logic [NUM_CH-1:0] calFailMeta_q;
  logic [NUM_CH-1:0] calFailSync_q;

  logic [63:0] readWord;
  logic [63:0] dfhWord;
  logic [63:0] emifStatus;
  logic [63:0] capMask;
  logic [63:0] featList2;
  logic [63:0] statusWord;
  logic [63:0] scratchMerged;
  logic        wrAccept;

  // Calibration results come from another clock domain; two flops each
  // before anything in this domain looks at them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calSuccMeta_q <= '0;
      calSuccSync_q <= '0;
      calFailMeta_q <= '0;
      calFailSync_q <= '0;
    end else begin
      calSuccMeta_q <= cal_success;
      calSuccSync_q <= calSuccMeta_q;
      calFailMeta_q <= cal_fail;
      calFailSync_q <= calFailMeta_q;
    end
  end

  // Fixed-layout words that feed the read mux.
  always_comb begin
    dfhWord = {DFH_FEAT_TYPE, 8'h00, DFH_MINOR_VER, 7'h00, DFH_EOL,
               DFH_NXT_OFFSET, DFH_MAJOR_VER, DFH_FEAT_ID};

    emifStatus = '0;
    emifStatus[NUM_CH-1:0]  = calSuccSync_q;
    emifStatus[16 +: NUM_CH] = calFailSync_q;

    capMask = '0;
    capMask[NUM_CH-1:0] = '1;

    featList2 = '0;
    featList2[3:0] = 4'(NUM_CH);

    statusWord = '0;
    statusWord[0] = &calSuccSync_q;
    statusWord[1] = |calFailSync_q;
  end

  // Read address decode. Anything not matched reads as zero; channel
  // attribute slots exist only for the channels actually present.
  always_comb begin
    readWord = '0;
    case (s_araddr)
      ADDR_DFH:         readWord = dfhWord;
      ADDR_EMIF_STATUS: readWord = emifStatus;
      ADDR_EMIF_CAP:    readWord = capMask;
      ADDR_VERSION:     readWord = 64'h0000_0000_0001_0000;
      ADDR_FEAT_LIST:   readWord = 64'h0000_0000_0001_0000;
      ADDR_FEAT_LIST_2: readWord = featList2;
      ADDR_IF_ATTR:     readWord = '0;
      ADDR_SCRATCH:     readWord = scratch_q;
      ADDR_STATUS:      readWord = statusWord;
      ADDR_EFFMON_CTRL: readWord = 64'(effmonEn_q);
      default:          readWord = '0;
    endcase
    for (int n = 0; n < NUM_CH; n++) begin
      if (s_araddr == ADDR_W'(CH_ATTR_BASE + 8 * n)) begin
        readWord = CH_ATTR_WORD;
      end
    end
  end

  // Read channel. arready is high only in IDLE, so any arvalid seen there
  // is a handshake; the next read can be taken the cycle after rready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdState_q <= RD_INIT;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (rdState_q)
        RD_INIT: begin
          arready_q <= 1'b1;
          rdState_q <= RD_IDLE;
        end
        RD_IDLE: begin
          if (s_arvalid) begin
            rdata_q   <= readWord;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rdState_q <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (s_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rdState_q <= RD_IDLE;
          end
        end
        default: begin
          arready_q <= 1'b0;
          rvalid_q  <= 1'b0;
          rdState_q <= RD_INIT;
        end
      endcase
    end
  end

  // Address and data are only taken together, so a lone AW or W beat
  // simply waits with its ready low.
  assign wrAccept = wrIdle_q && s_awvalid && s_wvalid;

  always_comb begin
    scratchMerged = scratch_q;
    for (int i = 0; i < 8; i++) begin
      if (s_wstrb[i]) begin
        scratchMerged[8*i +: 8] = s_wdata[8*i +: 8];
      end
    end
  end

  // Write channel and writable registers. A read taken on the same edge
  // sees the old scratch value because both sample scratch_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrState_q  <= WR_INIT;
      wrIdle_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      scratch_q  <= '0;
      effmonEn_q <= 1'b1;
    end else begin
      case (wrState_q)
        WR_INIT: begin
          wrIdle_q  <= 1'b1;
          wrState_q <= WR_IDLE;
        end
        WR_IDLE: begin
          if (wrAccept) begin
            bvalid_q  <= 1'b1;
            wrIdle_q  <= 1'b0;
            wrState_q <= WR_RESP;
            if (s_awaddr == ADDR_SCRATCH) begin
              scratch_q <= scratchMerged;
            end
            if (s_awaddr == ADDR_EFFMON_CTRL && s_wstrb[0]) begin
              effmonEn_q <= s_wdata[0];
            end
          end
        end
        WR_RESP: begin
          if (s_bready) begin
            bvalid_q  <= 1'b0;
            wrIdle_q  <= 1'b1;
            wrState_q <= WR_IDLE;
          end
        end
        default: begin
          wrIdle_q  <= 1'b0;
          bvalid_q  <= 1'b0;
          wrState_q <= WR_INIT;
        end
      endcase
    end
  end

  assign s_awready = wrAccept;
  assign s_wready  = wrAccept;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = 2'b00;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = 2'b00;
  assign effmon_en = effmonEn_q;

endmodule
